data_memory_banked: RTL and testbench
=====================================

// Module: data_memory_banked
// PURPOSE
// - Parametrised word-addressed data memory for the unpipelined processor; next generation of the 512x32 debug memory.
// - Adds byte-enable writes, a sequenced reset initialisation, a registered read with valid, a registered debug peek port and out-of-range detection.
// - Keeps the debug write gate: a captured store is held pending until writeEnable (button) commits it.
// - Sits between the datapath MEM stage and the board debugger (switch/LED peek).
// PARAMETERS
// - DATA_W   32   word width in bits; must be a multiple of 8
// - DEPTH    512  number of words; any value >= 2
// - ADDR_W   32   address port width; word index = addr (no byte offset)
// PORTS
// - Clk          in   1          single clock, all state on posedge
// - Rst          in   1          synchronous, active-high reset
// - addr         in   ADDR_W     word address for read/write
// - writeData    in   DATA_W     store data
// - byteEn       in   DATA_W/8   byte lane enables for stores; bit b covers data[8b+7:8b]
// - memWrite     in   1          store request (sampled in IDLE only)
// - memRead      in   1          load request
// - writeEnable  in   1          debug commit gate for a pending store
// - peekAddr     in   ADDR_W     debugger view address
// - readData     out  DATA_W     load result, registered
// - readValid    out  1          one-cycle pulse, readData valid
// - peekData     out  DATA_W     mem[peekAddr], registered
// - busy         out  1          high during INIT
// - writePending out  1          store captured, awaiting writeEnable
// - addrErr      out  1          one-cycle pulse: load or store with addr >= DEPTH
// BEHAVIOUR
// - Reset (Rst=1 at posedge): state<=INIT, initCnt<=0, pending store discarded; readData=0, readValid=0, peekData=0,
//   busy=1, writePending=0, addrErr=0. Reset mid-store or mid-INIT restarts INIT from word 0.
// - States: INIT -> IDLE -> WAIT -> COMMIT -> IDLE.
// - INIT: one word per cycle, mem[initCnt]<=initCnt (zero-extended/truncated to DATA_W); after DEPTH cycles -> IDLE, busy<=0.
//   memRead/memWrite ignored; readValid, addrErr stay 0; peekData held at 0.
// - IDLE: memWrite with addr<DEPTH captures addr, writeData, byteEn; -> WAIT, writePending<=1.
//   memWrite with addr>=DEPTH: store dropped, addrErr pulses, stay IDLE.
// - WAIT: on first cycle with writeEnable=1 -> COMMIT; else hold. memWrite in WAIT/COMMIT is ignored (no overwrite, no error).
// - COMMIT: enabled bytes of mem[pAddr] replaced by pData bytes, disabled bytes kept; writePending<=0; -> IDLE.
//   Min store latency: capture at edge N, WAIT->COMMIT at N+1 (writeEnable=1), memory updated at N+2.
// - Loads: accepted in IDLE/WAIT/COMMIT. memRead at edge N -> readData=mem[addr], readValid=1 after edge N; readData holds until next load.
//   addr>=DEPTH: readData<=0, readValid=1, addrErr=1.
//   Load to the address being written in the COMMIT cycle returns the old (pre-commit) word.
// - Simultaneous memRead+memWrite in IDLE: both accepted; load returns pre-store data.
// - Peek: every non-INIT cycle peekData<=mem[peekAddr]; 0 if peekAddr>=DEPTH; never raises addrErr.
// - Range checks use the full ADDR_W address; upper bits are not truncated.
// STRUCTURE
// - Package data_mem_pkg: state encodings (INIT/IDLE/WAIT/COMMIT), default DATA_W/DEPTH/ADDR_W, log2 function for initCnt width.
// - One sub-module: dm_byte_merge (combinational; old word, new word, byteEn -> merged word), reused by later cache work.
// - Storage is a single reg array; FSM, init counter, pending registers and output registers live in the top.
// TESTING
// - Reset, DEPTH=512: busy=1 for exactly 512 cycles, then peekAddr=37 -> peekData=37 one cycle later; readValid stays 0 during INIT.
// - Store addr=5, data=0xDEADBEEF, byteEn=4'b1111, writeEnable held 0 for 10 cycles: writePending=1 throughout, mem[5]=5;
//   raise writeEnable -> mem[5]=0xDEADBEEF two edges later, writePending=0.
// - Byte merge: mem[8]=8, store 0xAABBCCDD byteEn=4'b0101, commit -> load addr=8 returns 0x00BB00DD.
// - Out of range: load addr=512 -> readData=0, readValid=1, addrErr=1 for one cycle; store addr=600 -> no state change, addrErr=1.
// - Second memWrite (addr=6) during WAIT is dropped: after commit mem[5] new, mem[6]=6; load of addr=5 in COMMIT cycle returns 5.
// - Assert Rst while in WAIT: writePending=0 next cycle, INIT reruns, captured store never reaches memory.

Source files
------------

// File: rtl/data_memory_banked_pkg.sv
// Shared types and defaults for the banked data memory: FSM encoding and
// the index-width helper used to size the init counter and word index.
package data_mem_pkg;

    localparam int DM_DATA_W = 32;
    localparam int DM_DEPTH  = 512;
    localparam int DM_ADDR_W = 32;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_WAIT   = 2'd2,
        S_COMMIT = 2'd3
    } dm_state_e;

    // Ceiling log2, never below 1 so a 2-word memory still gets a 1-bit index.
    function automatic int dm_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/data_memory_banked_if.sv
// Datapath/debugger bus of the banked data memory; clock and reset stay plain ports.
interface data_memory_banked_if
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DM_DATA_W,
    parameter int ADDR_W = DM_ADDR_W
);
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   writeData;
    logic [DATA_W/8-1:0] byteEn;
    logic                memWrite;
    logic                memRead;
    logic                writeEnable;
    logic [ADDR_W-1:0]   peekAddr;
    logic [DATA_W-1:0]   readData;
    logic                readValid;
    logic [DATA_W-1:0]   peekData;
    logic                busy;
    logic                writePending;
    logic                addrErr;

    modport master (
        output addr, writeData, byteEn, memWrite, memRead, writeEnable, peekAddr,
        input  readData, readValid, peekData, busy, writePending, addrErr
    );

    modport slave (
        input  addr, writeData, byteEn, memWrite, memRead, writeEnable, peekAddr,
        output readData, readValid, peekData, busy, writePending, addrErr
    );
endinterface

// File: rtl/data_memory_banked_byte_merge.sv
// Combinational byte-lane merge: enabled lanes take the new word, others keep the old.
module dm_byte_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_word,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   merged
);
    for (genvar b = 0; b < DATA_W/8; b++) begin : g_lane
        assign merged[8*b +: 8] = byte_en[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
endmodule

// File: rtl/data_memory_banked.sv
// Word-addressed data memory with sequenced init, button-gated stores,
// registered loads with valid, registered debug peek and range errors.
module data_memory_banked
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DM_DATA_W,
    parameter int DEPTH  = DM_DEPTH,
    parameter int ADDR_W = DM_ADDR_W
) (
    input logic                 Clk,
    input logic                 Rst,
    data_memory_banked_if.slave bus
);
    localparam int IDX_W = dm_log2(DEPTH);
    localparam int BE_W  = DATA_W / 8;

    // Full-width compare so high address bits can never alias into range.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 64'(a) < 64'(DEPTH);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    dm_state_e         state_q, state_d;
    logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
    logic [IDX_W-1:0]  p_addr_q, p_addr_d;
    logic [DATA_W-1:0] p_data_q, p_data_d;
    logic [BE_W-1:0]   p_be_q, p_be_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              read_valid_q, read_valid_d;
    logic [DATA_W-1:0] peek_data_q, peek_data_d;
    logic              write_pending_q, write_pending_d;
    logic              addr_err_q, addr_err_d;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] commit_old;
    logic [DATA_W-1:0] merged_word;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  pk_idx;

    assign rd_idx     = bus.addr[IDX_W-1:0];
    assign pk_idx     = bus.peekAddr[IDX_W-1:0];
    assign commit_old = mem[p_addr_q];

    dm_byte_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word (commit_old),
        .new_word (p_data_q),
        .byte_en  (p_be_q),
        .merged   (merged_word)
    );

    always_comb begin
        state_d         = state_q;
        init_cnt_d      = init_cnt_q;
        p_addr_d        = p_addr_q;
        p_data_d        = p_data_q;
        p_be_d          = p_be_q;
        read_data_d     = read_data_q;
        read_valid_d    = 1'b0;
        peek_data_d     = peek_data_q;
        write_pending_d = write_pending_q;
        addr_err_d      = 1'b0;
        mem_we          = 1'b0;
        mem_waddr       = p_addr_q;
        mem_wdata       = merged_word;

        case (state_q)
            S_INIT: begin
                mem_we      = 1'b1;
                mem_waddr   = init_cnt_q;
                mem_wdata   = DATA_W'(init_cnt_q);
                peek_data_d = '0;
                if (init_cnt_q == IDX_W'(DEPTH - 1)) state_d = S_IDLE;
                else init_cnt_d = init_cnt_q + IDX_W'(1);
            end
            S_IDLE: begin
                if (bus.memWrite) begin
                    if (in_range(bus.addr)) begin
                        p_addr_d        = rd_idx;
                        p_data_d        = bus.writeData;
                        p_be_d          = bus.byteEn;
                        write_pending_d = 1'b1;
                        state_d         = S_WAIT;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.writeEnable) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                mem_we          = 1'b1;
                write_pending_d = 1'b0;
                state_d         = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase

        // Reads sample the array before this edge's write, so a load or peek
        // of the word being committed sees the old contents.
        if (state_q != S_INIT) begin
            if (bus.memRead) begin
                read_valid_d = 1'b1;
                if (in_range(bus.addr)) begin
                    read_data_d = mem[rd_idx];
                end else begin
                    read_data_d = '0;
                    addr_err_d  = 1'b1;
                end
            end
            peek_data_d = in_range(bus.peekAddr) ? mem[pk_idx] : '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q         <= S_INIT;
            init_cnt_q      <= '0;
            p_addr_q        <= '0;
            p_data_q        <= '0;
            p_be_q          <= '0;
            read_data_q     <= '0;
            read_valid_q    <= 1'b0;
            peek_data_q     <= '0;
            write_pending_q <= 1'b0;
            addr_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            init_cnt_q      <= init_cnt_d;
            p_addr_q        <= p_addr_d;
            p_data_q        <= p_data_d;
            p_be_q          <= p_be_d;
            read_data_q     <= read_data_d;
            read_valid_q    <= read_valid_d;
            peek_data_q     <= peek_data_d;
            write_pending_q <= write_pending_d;
            addr_err_q      <= addr_err_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we && !Rst) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.readData     = read_data_q;
    assign bus.readValid    = read_valid_q;
    assign bus.peekData     = peek_data_q;
    assign bus.busy         = (state_q == S_INIT);
    assign bus.writePending = write_pending_q;
    assign bus.addrErr      = addr_err_q;
endmodule

// File: tb/tb_data_memory_banked.sv
// Bench for data_memory_banked: load/peek vector table plus store, merge,
// range and reset sequences; load results checked through a scoreboard queue.
module tb_data_memory_banked;
    localparam int DW  = 32;
    localparam int DEP = 512;
    localparam int AW  = 32;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    data_memory_banked_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

    data_memory_banked #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rd_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] peek;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_peek;
    } vec_t;

    rd_exp_t     rq[$];
    vec_t        vt[8];
    logic [31:0] ref_mem[DEP];
    logic [31:0] last_rd = 32'h0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_init;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock edge; then readValid/readData/addrErr are checked against the scoreboard.
    task automatic tick(input logic st_err);
        rd_exp_t e;
        logic    exp_rv, exp_err, in_rst;
        in_rst = Rst;
        @(posedge Clk);
        #1;
        exp_rv  = 1'b0;
        exp_err = st_err;
        if (in_rst) last_rd = 32'h0;
        if (rq.size() > 0) begin
            e       = rq.pop_front();
            exp_rv  = 1'b1;
            exp_err = exp_err | e.err;
            last_rd = e.data;
        end
        check("readValid", {31'b0, bus.readValid}, {31'b0, exp_rv});
        check("readData", bus.readData, last_rd);
        check("addrErr", {31'b0, bus.addrErr}, {31'b0, exp_err});
    endtask

    task automatic load(input logic [31:0] a);
        logic [31:0] d;
        logic        er;
        er = (a >= DEP);
        d  = er ? 32'h0 : ref_mem[a[8:0]];
        bus.memRead = 1'b1;
        bus.addr    = a;
        rq.push_back('{data: d, err: er});
    endtask

    task automatic do_load(input logic [31:0] a);
        load(a);
        tick(1'b0);
        bus.memRead = 1'b0;
    endtask

    // Counts cycles with busy high, starting from the current sample; bounded.
    task automatic wait_init(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin
            check("peek_init", bus.peekData, 32'h0);
            n++;
            tick(1'b0);
        end
    endtask

    task automatic ref_identity();
        for (int i = 0; i < DEP; i++) ref_mem[i] = i;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        Rst             = 1'b1;
        bus.addr        = '0;
        bus.writeData   = '0;
        bus.byteEn      = '0;
        bus.memWrite    = 1'b0;
        bus.memRead     = 1'b0;
        bus.writeEnable = 1'b0;
        bus.peekAddr    = '0;
        repeat (3) tick(1'b0);
        check("rst_busy", {31'b0, bus.busy}, 32'd1);
        check("rst_peek", bus.peekData, 32'h0);
        check("rst_pend", {31'b0, bus.writePending}, 32'd0);

        // INIT with loads/stores hammering the bus: all must be ignored
        Rst           = 1'b0;
        bus.memRead   = 1'b1;
        bus.memWrite  = 1'b1;
        bus.addr      = 32'd3;
        bus.writeData = 32'hFFFF_FFFF;
        bus.byteEn    = 4'hF;
        bus.peekAddr  = 32'd37;
        wait_init(n_init);
        check("init_cycles", n_init, 32'd512);
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        check("peek_last_init", bus.peekData, 32'h0);
        check("pend_after_init", {31'b0, bus.writePending}, 32'd0);
        tick(1'b0);
        check("peek37", bus.peekData, 32'd37);
        ref_identity();

        vt[0] = '{32'd0,          32'd1,          32'd0,   1'b0, 32'd1};
        vt[1] = '{32'd1,          32'd511,        32'd1,   1'b0, 32'd511};
        vt[2] = '{32'd37,         32'd0,          32'd37,  1'b0, 32'd0};
        vt[3] = '{32'd511,        32'd512,        32'd511, 1'b0, 32'd0};
        vt[4] = '{32'd512,        32'd100,        32'd0,   1'b1, 32'd100};
        vt[5] = '{32'h8000_0005,  32'h8000_0005,  32'd0,   1'b1, 32'd0};
        vt[6] = '{32'hFFFF_FFFF,  32'd256,        32'd0,   1'b1, 32'd256};
        vt[7] = '{32'd3,          32'd300,        32'd3,   1'b0, 32'd300};
        for (int i = 0; i < 8; i++) begin
            bus.memRead  = 1'b1;
            bus.addr     = vt[i].addr;
            bus.peekAddr = vt[i].peek;
            rq.push_back('{data: vt[i].exp_rd, err: vt[i].exp_err});
            tick(1'b0);
            check("vec_peek", bus.peekData, vt[i].exp_peek);
        end
        bus.memRead = 1'b0;
        tick(1'b0);

        // Gated store: pending while writeEnable low, second store dropped
        bus.peekAddr  = 32'd5;
        bus.memWrite  = 1'b1;
        bus.addr      = 32'd5;
        bus.writeData = 32'hDEAD_BEEF;
        bus.byteEn    = 4'hF;
        tick(1'b0);
        bus.memWrite = 1'b0;
        check("pend_capture", {31'b0, bus.writePending}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.memWrite  = 1'b1;
                bus.addr      = 32'd6;
                bus.writeData = 32'h1234_5678;
            end
            tick(1'b0);
            bus.memWrite = 1'b0;
            check("pend_hold", {31'b0, bus.writePending}, 32'd1);
            check("peek5_old", bus.peekData, 32'd5);
        end
        bus.writeEnable = 1'b1;
        tick(1'b0);
        check("pend_in_commit", {31'b0, bus.writePending}, 32'd1);
        bus.writeEnable = 1'b0;
        load(32'd5);
        tick(1'b0);
        bus.memRead = 1'b0;
        check("pend_cleared", {31'b0, bus.writePending}, 32'd0);
        ref_mem[5] = 32'hDEAD_BEEF;
        do_load(32'd5);
        do_load(32'd6);
        check("peek5_new", bus.peekData, 32'hDEAD_BEEF);

        // Byte merge with a simultaneous load of the same word
        bus.memWrite    = 1'b1;
        bus.writeData   = 32'hAABB_CCDD;
        bus.byteEn      = 4'b0101;
        bus.writeEnable = 1'b1;
        load(32'd8);
        tick(1'b0);
        bus.memWrite = 1'b0;
        bus.memRead  = 1'b0;
        check("merge_pend", {31'b0, bus.writePending}, 32'd1);
        tick(1'b0);
        bus.writeEnable = 1'b0;
        tick(1'b0);
        check("merge_pend_clr", {31'b0, bus.writePending}, 32'd0);
        ref_mem[8] = 32'h00BB_00DD;
        do_load(32'd8);
        do_load(32'd9);

        // Out-of-range store: error pulse only, 600 must not alias to 88
        bus.memWrite  = 1'b1;
        bus.addr      = 32'd600;
        bus.writeData = 32'h5555_5555;
        bus.byteEn    = 4'hF;
        tick(1'b1);
        bus.memWrite = 1'b0;
        check("oor_store_pend", {31'b0, bus.writePending}, 32'd0);
        tick(1'b0);
        do_load(32'd88);

        // Reset while a store waits: it is discarded and INIT reruns
        bus.memWrite  = 1'b1;
        bus.addr      = 32'd10;
        bus.writeData = 32'hCAFE_F00D;
        tick(1'b0);
        bus.memWrite = 1'b0;
        tick(1'b0);
        check("wait_pend", {31'b0, bus.writePending}, 32'd1);
        Rst             = 1'b1;
        bus.writeEnable = 1'b1;
        tick(1'b0);
        check("rst_wait_pend", {31'b0, bus.writePending}, 32'd0);
        check("rst_wait_busy", {31'b0, bus.busy}, 32'd1);
        check("rst_wait_peek", bus.peekData, 32'h0);
        Rst         = 1'b0;
        bus.memRead = 1'b1;
        bus.addr    = 32'd10;
        wait_init(n_init);
        check("reinit_cycles", n_init, 32'd512);
        bus.memRead     = 1'b0;
        bus.writeEnable = 1'b0;
        ref_identity();
        do_load(32'd10);
        do_load(32'd5);
        tick(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
